// File: rtl/corescore_stream_pkg.sv
// Shared constants and the FIFO entry layout for the JTAG-UART receive stream.
// Each buffered entry carries the received byte plus a precomputed "last" flag,
// so the read side never has to compare bytes combinationally.
package corescore_stream_pkg;

    localparam int STREAM_W = 8;
    localparam logic [STREAM_W-1:0] EOL_DEFAULT = 8'h0A;

    // Entry layout: {last, data[7:0]}
    localparam int LAST_BIT = 8;
    localparam int ENTRY_W  = 9;

    typedef struct packed {
        logic                last;
        logic [STREAM_W-1:0] data;
    } stream_entry_t;

endpackage

// File: rtl/corescore_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Ports:
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_wr, i_wdata       write request and entry; ignored while full
//   i_rd                pop request; ignored while empty
//   o_rdata             entry at the read pointer (valid while !o_empty)
//   o_fill_next         occupancy after the current edge (for registered flow control)
//   o_full, o_empty     registered occupancy flags
// A write while full is refused even if a pop happens in the same cycle.
module corescore_sync_fifo
    import corescore_stream_pkg::*;
#(
    parameter int P_ENTRY_W = ENTRY_W,
    parameter int AW        = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_wr,
    input  logic [P_ENTRY_W-1:0] i_wdata,
    input  logic                 i_rd,
    output logic [P_ENTRY_W-1:0] o_rdata,
    output logic [AW:0]          o_fill_next,
    output logic                 o_full,
    output logic                 o_empty
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0]   FILL_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   FILL_DEPTH = {1'b1, {AW{1'b0}}};
    localparam logic [AW-1:0] PTR_ONE    = {{(AW-1){1'b0}}, 1'b1};

    logic [P_ENTRY_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_fill;
    logic                 r_full;
    logic                 r_empty;

    logic                 w_do_wr;
    logic                 w_do_rd;
    logic [AW:0]          w_fill_next;

    assign w_do_wr = i_wr & ~r_full;
    assign w_do_rd = i_rd & ~r_empty;

    always_comb begin
        w_fill_next = r_fill;
        case ({w_do_wr, w_do_rd})
            2'b10:   w_fill_next = r_fill + FILL_ONE;
            2'b01:   w_fill_next = r_fill - FILL_ONE;
            default: w_fill_next = r_fill;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_fill  <= w_fill_next;
            r_full  <= (w_fill_next == FILL_DEPTH);
            r_empty <= (w_fill_next == '0);
        end
    end

    // Storage needs no reset: contents are only observable while not empty.
    always_ff @(posedge i_clk) begin
        if (w_do_wr) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata     = r_mem[r_rd_ptr];
    assign o_fill_next = w_fill_next;
    assign o_full      = r_full;
    assign o_empty     = r_empty;

    a_no_pop_when_empty: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_rd && r_empty));

endmodule

// File: rtl/corescore_jtag_rx_stream.sv
// Host-to-FPGA side of the JTAG-UART link: buffers bytes strobed out of the
// JTAG-UART receive port and presents them as a valid/ready byte stream.
// Ports:
//   i_clk, i_rst_n    clock, synchronous active-low reset
//   i_dat, i_ena      received byte and its one-cycle strobe (t_dat/t_ena)
//   o_dav             space available toward the JTAG-UART (t_dav), registered
//   o_tdata, o_tlast  stream byte and end-of-line flag
//   o_tvalid          stream valid; i_tready pops a beat when both are high
//   o_overflow        sticky: a strobed byte arrived while the FIFO was full
//   o_count           bytes accepted into the FIFO, modulo 2**CW
// Handshake: a beat transfers on a rising edge where o_tvalid and i_tready are
// both high; o_tdata/o_tlast hold steady while o_tvalid is high and i_tready low.
module corescore_jtag_rx_stream
    import corescore_stream_pkg::*;
#(
    parameter int                  AW       = 4,
    parameter logic [STREAM_W-1:0] EOL_CHAR = EOL_DEFAULT,
    parameter int                  HEADROOM = 1,
    parameter int                  CW       = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [STREAM_W-1:0] i_dat,
    input  logic                i_ena,
    output logic                o_dav,
    output logic [STREAM_W-1:0] o_tdata,
    output logic                o_tvalid,
    output logic                o_tlast,
    input  logic                i_tready,
    output logic                o_overflow,
    output logic [CW-1:0]       o_count
);

    localparam int          DAV_LIMIT_I = (1 << AW) - HEADROOM;
    localparam logic [AW:0] DAV_LIMIT   = DAV_LIMIT_I[AW:0];
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

    stream_entry_t w_wentry;
    stream_entry_t w_rentry;
    logic [AW:0]   w_fill_next;
    logic          w_full;
    logic          w_empty;
    logic          w_accept;
    logic          w_pop;

    logic          r_dav;
    logic          r_overflow;
    logic [CW-1:0] r_count;

    // Tag end-of-line on the way in so the read side is a plain register read.
    assign w_wentry.last = (i_dat == EOL_CHAR);
    assign w_wentry.data = i_dat;

    assign w_accept = i_ena & ~w_full;
    assign w_pop    = ~w_empty & i_tready;

    corescore_sync_fifo #(
        .P_ENTRY_W (ENTRY_W),
        .AW        (AW)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_wr        (i_ena),
        .i_wdata     (w_wentry),
        .i_rd        (w_pop),
        .o_rdata     (w_rentry),
        .o_fill_next (w_fill_next),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // o_dav looks at next-cycle occupancy so the source's one-cycle strobe
    // latency lands in the reserved headroom rather than overflowing.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_dav      <= 1'b0;
            r_overflow <= 1'b0;
            r_count    <= '0;
        end else begin
            r_dav <= (w_fill_next < DAV_LIMIT);
            if (i_ena && w_full) r_overflow <= 1'b1;
            if (w_accept)        r_count    <= r_count + CNT_ONE;
        end
    end

    assign o_dav      = r_dav;
    assign o_tvalid   = ~w_empty;
    assign o_tdata    = w_rentry.data;
    assign o_tlast    = w_rentry.last;
    assign o_overflow = r_overflow;
    assign o_count    = r_count;

endmodule

// File: tb/tb_corescore_jtag_rx_stream.sv
module tb_corescore_jtag_rx_stream;

  localparam int DEPTH    = 16;
  localparam int HEADROOM = 1;
  localparam logic [7:0] EOL = 8'h0A;

  logic        i_clk;
  logic        i_rst_n;
  logic [7:0]  i_dat;
  logic        i_ena;
  logic        o_dav;
  logic [7:0]  o_tdata;
  logic        o_tvalid;
  logic        o_tlast;
  logic        i_tready;
  logic        o_overflow;
  logic [15:0] o_count;

  corescore_jtag_rx_stream dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_dat      (i_dat),
    .i_ena      (i_ena),
    .o_dav      (o_dav),
    .o_tdata    (o_tdata),
    .o_tvalid   (o_tvalid),
    .o_tlast    (o_tlast),
    .i_tready   (i_tready),
    .o_overflow (o_overflow),
    .o_count    (o_count)
  );

  // ---------------- clock ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- reference model state ----------------
  logic [8:0]  exp_q[$];     // bytes the FIFO should hold, oldest first, {last,data}
  int          model_fill;
  logic [15:0] model_count;
  logic        model_ovf;
  logic        model_dav;
  int          n_checks;
  int          n_fail;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  // ---------------- driver tasks ----------------
  // Applies one cycle of stimulus; the model decides acceptance from occupancy
  // before the edge, with no credit for a pop on the same edge.
  task automatic cycle(input logic ena, input logic [7:0] dat, input logic rdy);
    bit acc;
    bit pop;
    i_ena    = ena;
    i_dat    = dat;
    i_tready = rdy;
    acc = ena && (model_fill < DEPTH);
    pop = rdy && (model_fill > 0);
    if (acc) exp_q.push_back({dat == EOL, dat});
    @(posedge i_clk);
    #1;
    model_fill = model_fill + int'(acc) - int'(pop);
    if (acc) model_count = model_count + 16'd1;
    if (ena && !acc) model_ovf = 1'b1;
    model_dav = (model_fill < DEPTH - HEADROOM);
  endtask

  task automatic do_reset();
    i_rst_n  = 1'b0;
    i_ena    = 1'b0;
    i_dat    = 8'h00;
    i_tready = 1'b0;
    exp_q.delete();
    model_fill  = 0;
    model_count = '0;
    model_ovf   = 1'b0;
    model_dav   = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) cycle(1'b0, 8'h00, rdy);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic       stall;
  logic [8:0] held;

  always @(negedge i_clk) begin
    logic [8:0] e;
    if (!i_rst_n) begin
      stall = 1'b0;
    end else begin
      chk("tvalid",   32'(o_tvalid),   32'(model_fill != 0));
      chk("dav",      32'(o_dav),      32'(model_dav));
      chk("overflow", 32'(o_overflow), 32'(model_ovf));
      chk("count",    32'(o_count),    32'(model_count));
      if (stall && o_tvalid) chk("hold", 32'({o_tlast, o_tdata}), 32'(held));
      if (o_tvalid && i_tready) begin
        if (exp_q.size() == 0) begin
          chk("beat_unexpected", 32'({o_tlast, o_tdata}), 32'h1FF);
        end else begin
          e = exp_q.pop_front();
          chk("beat", 32'({o_tlast, o_tdata}), 32'(e));
        end
      end
      stall = o_tvalid && !i_tready;
      held  = {o_tlast, o_tdata};
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic       prev_dav;
    logic [7:0] d;
    n_checks = 0;
    n_fail   = 0;
    stall    = 1'b0;
    held     = '0;
    do_reset();

    // Reset then idle
    idle(4, 1'b0);

    // "hi\n" with the sink always ready
    cycle(1'b1, 8'h68, 1'b1);
    cycle(1'b1, 8'h69, 1'b1);
    cycle(1'b1, 8'h0A, 1'b1);
    idle(3, 1'b1);
    chk("count_hi", 32'(o_count), 32'd3);

    // Fill to 16 with the sink stalled; o_dav falls at 15
    for (int k = 0; k < 16; k++) cycle(1'b1, 8'(k), 1'b0);
    idle(3, 1'b0);
    chk("fill_full_ovf", 32'(o_overflow), 32'd0);

    // Strobe while full: dropped; also once with a simultaneous pop
    cycle(1'b1, 8'hAA, 1'b0);
    idle(2, 1'b0);
    cycle(1'b1, 8'hAA, 1'b1);
    idle(20, 1'b1);
    chk("drop_count", 32'(o_count), 32'd19);
    chk("drop_sticky", 32'(o_overflow), 32'd1);

    // Write and pop at fill==1
    cycle(1'b1, 8'h41, 1'b0);
    cycle(1'b1, 8'h55, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    idle(3, 1'b1);

    // Random traffic, source ignores o_dav (overflow allowed)
    for (int k = 0; k < 400; k++) begin
      d = ($urandom_range(0, 5) == 0) ? EOL : 8'($urandom_range(0, 255));
      cycle(1'($urandom_range(0, 9) < 6), d, 1'($urandom_range(0, 9) < 5));
    end
    idle(20, 1'b1);

    // Reset mid-frame with 7 bytes buffered
    for (int k = 0; k < 7; k++) cycle(1'b1, 8'h61 + 8'(k), 1'b0);
    do_reset();
    idle(1, 1'b0);
    cycle(1'b1, 8'h31, 1'b1);
    idle(3, 1'b1);
    chk("post_reset_count", 32'(o_count), 32'd1);

    // Random traffic with a source that honours o_dav one cycle late
    prev_dav = o_dav;
    for (int k = 0; k < 400; k++) begin
      logic ena;
      ena = prev_dav && ($urandom_range(0, 9) < 8);
      prev_dav = o_dav;
      d = ($urandom_range(0, 7) == 0) ? EOL : 8'($urandom_range(0, 255));
      cycle(ena, d, 1'($urandom_range(0, 9) < 3));
    end
    idle(24, 1'b1);
    chk("paced_no_overflow", 32'(o_overflow), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
